// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame-format encodings and the latched frame configuration.
package uart_pkg;

  localparam int unsigned BITCNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  typedef enum logic [1:0] {
    BITS_5 = 2'b00,
    BITS_6 = 2'b01,
    BITS_7 = 2'b10,
    BITS_8 = 2'b11
  } uart_bits_e;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_ODD   = 2'b10,
    PAR_NONE2 = 2'b11
  } uart_parity_e;

  typedef struct packed {
    logic [BITCNT_W-1:0] last_bit;
    logic                par_en;
    logic                par_odd;
    logic                stop2;
  } uart_frame_cfg_t;

  // Raw register fields -> per-frame configuration; last_bit is N-1 with N = 5 + cfg_bits.
  function automatic uart_frame_cfg_t decode_cfg(input logic [1:0] bits,
                                                 input logic [1:0] parity,
                                                 input logic       stop2);
    uart_frame_cfg_t c;
    c.last_bit = BITCNT_W'(3'd4 + {1'b0, bits});
    c.par_en   = (parity == 2'(PAR_EVEN)) || (parity == 2'(PAR_ODD));
    c.par_odd  = (parity == 2'(PAR_ODD));
    c.stop2    = stop2;
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Request handshake between the TX FIFO / host side and the UART serializer.
interface uart_tx_cfg_if #(
  parameter int unsigned DATA_W = 8
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;

  modport master (output tx_valid, output tx_data, input  tx_ready);
  modport slave  (input  tx_valid, input  tx_data, output tx_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Baud bit timer: down-counter loaded on frame start, ticks on the last clock of each bit and reloads.
module uart_bit_timer #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_bit_end_c
);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_div <= i_div;
      r_cnt <= i_div;
    end else if (i_run) begin
      r_cnt <= (r_cnt == '0) ? r_div : r_cnt - DIV_W'(1);
    end
  end

  assign o_bit_end_c = (r_cnt == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: programmable baud divider, 5-8 data bits, optional parity, 1/2 stop bits.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 16
) (
  input  logic             clk,
  input  logic             RST,
  uart_tx_cfg_if.slave     s_tx,
  input  logic [DIV_W-1:0] i_baud_div,
  input  logic [1:0]       i_cfg_bits,
  input  logic [1:0]       i_cfg_parity,
  input  logic             i_cfg_stop2,
  output logic             o_tx_out,
  output logic             o_busy,
  output logic             o_irq_done
);

  uart_state_e         r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_shift, w_shift_nxt;
  logic [BITCNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic                r_par, w_par_nxt;
  uart_frame_cfg_t     r_cfg, w_cfg_nxt;
  logic                r_stop_cnt, w_stop_cnt_nxt;
  logic                r_tx_out, w_tx_out_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_irq_done, w_irq_nxt;
  logic                r_ready, w_ready_nxt;
  logic                w_accept;
  logic                w_run;
  logic                w_tick;
  logic                w_bit_end;

  assign w_accept  = s_tx.tx_valid && r_ready;
  assign w_run     = (r_state != ST_IDLE);
  assign w_bit_end = w_run && w_tick;

  uart_bit_timer #(.DIV_W(DIV_W)) u_bit_timer (
    .clk         (clk),
    .RST         (RST),
    .i_load      (w_accept),
    .i_run       (w_run),
    .i_div       (i_baud_div),
    .o_bit_end_c (w_tick)
  );

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_par      <= 1'b0;
      r_cfg      <= '0;
      r_stop_cnt <= 1'b0;
      r_tx_out   <= 1'b1;
      r_busy     <= 1'b0;
      r_irq_done <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_par      <= w_par_nxt;
      r_cfg      <= w_cfg_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_tx_out   <= w_tx_out_nxt;
      r_busy     <= w_busy_nxt;
      r_irq_done <= w_irq_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  // Next-state logic; pin outputs are derived from the next state so they leave the flops glitch-free.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_par_nxt      = r_par;
    w_cfg_nxt      = r_cfg;
    w_stop_cnt_nxt = r_stop_cnt;
    w_irq_nxt      = 1'b0;
    w_tx_out_nxt   = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt    = ST_START;
          w_shift_nxt    = DATA_W'(s_tx.tx_data);
          w_bit_cnt_nxt  = '0;
          w_par_nxt      = 1'b0;
          w_cfg_nxt      = decode_cfg(i_cfg_bits, i_cfg_parity, i_cfg_stop2);
          w_stop_cnt_nxt = 1'b0;
        end
      end
      ST_START: begin
        if (w_bit_end) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_par_nxt   = r_par ^ r_shift[0];
          w_shift_nxt = r_shift >> 1;
          if (r_bit_cnt == r_cfg.last_bit) begin
            w_state_nxt = r_cfg.par_en ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BITCNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (r_cfg.stop2 && !r_stop_cnt) begin
            w_stop_cnt_nxt = 1'b1;
          end else begin
            w_stop_cnt_nxt = 1'b0;
            w_state_nxt    = ST_IDLE;
            w_irq_nxt      = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    case (w_state_nxt)
      ST_START:  w_tx_out_nxt = 1'b0;
      ST_DATA:   w_tx_out_nxt = w_shift_nxt[0];
      ST_PARITY: w_tx_out_nxt = w_par_nxt ^ r_cfg.par_odd;
      default:   w_tx_out_nxt = 1'b1;
    endcase

    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  assign s_tx.tx_ready = r_ready;
  assign o_tx_out      = r_tx_out;
  assign o_busy        = r_busy;
  assign o_irq_done    = r_irq_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg: frame formats, handshake, config latching and reset abort.
module tb_uart_tx_cfg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIV_W  = 16;

  logic             clk = 1'b0;
  logic             RST;
  logic [DIV_W-1:0] baud_div;
  logic [1:0]       cfg_bits;
  logic [1:0]       cfg_parity;
  logic             cfg_stop2;
  logic             tx_out;
  logic             busy;
  logic             irq_done;

  uart_tx_cfg_if #(.DATA_W(DATA_W)) tx_if ();

  uart_tx_cfg #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk          (clk),
    .RST          (RST),
    .s_tx         (tx_if.slave),
    .i_baud_div   (baud_div),
    .i_cfg_bits   (cfg_bits),
    .i_cfg_parity (cfg_parity),
    .i_cfg_stop2  (cfg_stop2),
    .o_tx_out     (tx_out),
    .o_busy       (busy),
    .o_irq_done   (irq_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] cap_line;
  logic [255:0] cap_busy;
  logic [255:0] cap_ready;
  int           irq_cnt;
  int           irq_at;
  int           irq_last;

  // Expected line waveform: bits[] in time order, each held d+1 clocks, starting at sample off.
  function automatic logic [255:0] expand(input logic [255:0] base, input logic [15:0] bits,
                                          input int nb, input int d, input int off);
    logic [255:0] v;
    v = base;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c <= d; c++)
        v[off + b*(d+1) + c] = bits[b];
    return v;
  endfunction

  task automatic clear_cap();
    cap_line  = '1;
    cap_busy  = '0;
    cap_ready = '0;
    irq_cnt   = 0;
    irq_at    = -1;
    irq_last  = -1;
  endtask

  // Sample k is taken 1 time unit after the k-th clock edge following the accept edge.
  task automatic capture(input int k0, input int k1, input int drop_k);
    for (int k = k0; k < k1; k++) begin
      if (k != 0) begin
        @(posedge clk);
        #1;
      end
      if (k == drop_k) tx_if.tx_valid = 1'b0;
      cap_line[k]  = tx_out;
      cap_busy[k]  = busy;
      cap_ready[k] = tx_if.tx_ready;
      if (irq_done) begin
        irq_cnt++;
        if (irq_at < 0) irq_at = k;
        irq_last = k;
      end
    end
  endtask

  // Wait for ready, present one request, return at sample point of the accept edge.
  task automatic send(input logic [7:0] data, input bit hold);
    int w;
    w = 0;
    while (!tx_if.tx_ready && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_ready_timeout: tx_ready=%b after %0d cycles, required 1", tx_if.tx_ready, w);
    end
    tx_if.tx_data  = data;
    tx_if.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) tx_if.tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    n_checks++;
    if (tx_out !== 1'b1) begin n_fail++; $display("FAIL rst_tx_out: got %b exp 1", tx_out); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_checks++;
    if (irq_done !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b exp 0", irq_done); end
    n_checks++;
    if (tx_if.tx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_in_reset: got %b exp 0", tx_if.tx_ready); end
    RST = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (tx_if.tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_idle: got %b exp 1", tx_if.tx_ready); end
    n_checks++;
    if (tx_out !== 1'b1) begin n_fail++; $display("FAIL rst_idle_line: got %b exp 1", tx_out); end
  endtask

  task automatic test_8n1();
    logic [255:0] e;
    baud_div = 16'd3; cfg_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    clear_cap();
    send(8'hA5, 1'b0);
    capture(0, 45, -1);
    e = expand('1, 16'({1'b1, 8'hA5, 1'b0}), 10, 3, 0);
    n_checks++;
    if (cap_line !== e) begin n_fail++; $display("FAIL 8n1_line: got %h exp %h", cap_line, e); end
    n_checks++;
    if (irq_at !== 40) begin n_fail++; $display("FAIL 8n1_irq_at: got %0d exp 40", irq_at); end
    n_checks++;
    if (irq_cnt !== 1) begin n_fail++; $display("FAIL 8n1_irq_cnt: got %0d exp 1", irq_cnt); end
    n_checks++;
    if (cap_busy[44:0] !== {5'b0, {40{1'b1}}}) begin
      n_fail++; $display("FAIL 8n1_busy: got %h exp %h", cap_busy[44:0], {5'b0, {40{1'b1}}});
    end
    n_checks++;
    if (cap_ready[44:0] !== {5'b11111, 40'b0}) begin
      n_fail++; $display("FAIL 8n1_ready: got %h exp %h", cap_ready[44:0], {5'b11111, 40'b0});
    end
  endtask

  task automatic test_7e1();
    logic [255:0] e;
    baud_div = 16'd0; cfg_bits = 2'b10; cfg_parity = 2'b01; cfg_stop2 = 1'b0;
    clear_cap();
    send(8'hFF, 1'b0);
    capture(0, 13, -1);
    e = expand('1, 16'({1'b1, 1'b1, 7'h7F, 1'b0}), 10, 0, 0);
    n_checks++;
    if (cap_line !== e) begin n_fail++; $display("FAIL 7e1_line: got %h exp %h", cap_line, e); end
    n_checks++;
    if (irq_at !== 10) begin n_fail++; $display("FAIL 7e1_irq_at: got %0d exp 10", irq_at); end
    n_checks++;
    if (irq_cnt !== 1) begin n_fail++; $display("FAIL 7e1_irq_cnt: got %0d exp 1", irq_cnt); end
  endtask

  task automatic test_5o2();
    logic [255:0] e;
    baud_div = 16'd1; cfg_bits = 2'b00; cfg_parity = 2'b10; cfg_stop2 = 1'b1;
    clear_cap();
    send(8'h03, 1'b0);
    capture(0, 21, -1);
    e = expand('1, 16'({1'b1, 1'b1, 1'b1, 5'b00011, 1'b0}), 9, 1, 0);
    n_checks++;
    if (cap_line !== e) begin n_fail++; $display("FAIL 5o2_line: got %h exp %h", cap_line, e); end
    n_checks++;
    if (irq_at !== 18) begin n_fail++; $display("FAIL 5o2_irq_at: got %0d exp 18", irq_at); end
    n_checks++;
    if (irq_cnt !== 1) begin n_fail++; $display("FAIL 5o2_irq_cnt: got %0d exp 1", irq_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] e;
    baud_div = 16'd1; cfg_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    clear_cap();
    send(8'h55, 1'b1);
    tx_if.tx_data = 8'h0F;
    capture(0, 44, 21);
    e = expand(expand('1, 16'({1'b1, 8'h55, 1'b0}), 10, 1, 0), 16'({1'b1, 8'h0F, 1'b0}), 10, 1, 21);
    n_checks++;
    if (cap_line !== e) begin n_fail++; $display("FAIL b2b_line: got %h exp %h", cap_line, e); end
    n_checks++;
    if (irq_cnt !== 2) begin n_fail++; $display("FAIL b2b_irq_cnt: got %0d exp 2", irq_cnt); end
    n_checks++;
    if (irq_at !== 20 || irq_last !== 41) begin
      n_fail++; $display("FAIL b2b_irq_pos: got %0d/%0d exp 20/41", irq_at, irq_last);
    end
    n_checks++;
    if (cap_ready[40:0] !== (41'(1) << 20)) begin
      n_fail++; $display("FAIL b2b_ready: got %h exp %h", cap_ready[40:0], (41'(1) << 20));
    end
  endtask

  task automatic test_cfg_change();
    logic [255:0] e;
    baud_div = 16'd1; cfg_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    clear_cap();
    send(8'h3C, 1'b0);
    capture(0, 3, -1);
    baud_div = 16'd0; cfg_bits = 2'b00; cfg_parity = 2'b01; tx_if.tx_data = 8'hFF;
    capture(3, 22, -1);
    e = expand('1, 16'({1'b1, 8'h3C, 1'b0}), 10, 1, 0);
    n_checks++;
    if (cap_line !== e) begin n_fail++; $display("FAIL cfgchg_old_line: got %h exp %h", cap_line, e); end
    n_checks++;
    if (irq_at !== 20) begin n_fail++; $display("FAIL cfgchg_old_irq_at: got %0d exp 20", irq_at); end
    clear_cap();
    send(8'hFF, 1'b0);
    capture(0, 10, -1);
    e = expand('1, 16'({1'b1, 1'b1, 5'h1F, 1'b0}), 8, 0, 0);
    n_checks++;
    if (cap_line !== e) begin n_fail++; $display("FAIL cfgchg_new_line: got %h exp %h", cap_line, e); end
    n_checks++;
    if (irq_at !== 8) begin n_fail++; $display("FAIL cfgchg_new_irq_at: got %0d exp 8", irq_at); end
  endtask

  task automatic test_reset_mid_frame();
    logic [255:0] e;
    int irq_seen;
    baud_div = 16'd2; cfg_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    clear_cap();
    send(8'hA5, 1'b0);
    capture(0, 14, -1);
    e = expand('1, 16'({1'b1, 8'hA5, 1'b0}), 10, 2, 0);
    n_checks++;
    if (cap_line[13:0] !== e[13:0]) begin
      n_fail++; $display("FAIL rstmid_pre_line: got %h exp %h", cap_line[13:0], e[13:0]);
    end
    RST = 1'b0;
    #1;
    n_checks++;
    if (tx_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx_out: got %b exp 1", tx_out); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b exp 0", busy); end
    n_checks++;
    if (tx_if.tx_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b exp 0", tx_if.tx_ready); end
    irq_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (irq_done) irq_seen++;
    end
    RST = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (irq_done) irq_seen++;
    end
    n_checks++;
    if (irq_seen !== 0) begin n_fail++; $display("FAIL rstmid_no_irq: got %0d pulses exp 0", irq_seen); end
    baud_div = 16'd0;
    clear_cap();
    send(8'h3C, 1'b0);
    capture(0, 13, -1);
    e = expand('1, 16'({1'b1, 8'h3C, 1'b0}), 10, 0, 0);
    n_checks++;
    if (cap_line !== e) begin n_fail++; $display("FAIL rstmid_next_line: got %h exp %h", cap_line, e); end
    n_checks++;
    if (irq_at !== 10 || irq_cnt !== 1) begin
      n_fail++; $display("FAIL rstmid_next_irq: got at %0d cnt %0d exp at 10 cnt 1", irq_at, irq_cnt);
    end
  endtask

  initial begin
    RST            = 1'b0;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = '0;
    baud_div       = '0;
    cfg_bits       = 2'b11;
    cfg_parity     = 2'b00;
    cfg_stop2      = 1'b0;
    test_reset();
    test_8n1();
    test_7e1();
    test_5o2();
    test_back_to_back();
    test_cfg_change();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
